// File: rtl/split_stream.sv
// split_stream: collects one problem instance of NUM_VARS words from a
// valid/ready stream, checks framing, and produces a one-bit result.
//   MODE 0: tautology, x is always 1.
//   MODE 1: range check, x = AND over all words of (word <= LIMIT).
// Optional feature: define SPLIT_STREAM_SIG_EN to add the sig output, a
// rotate-left-1/XOR signature of the accepted words.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a new instance (sampled in IDLE only)
//   in_valid/in_ready/in_data/in_last  input word stream
//   busy          high while collecting
//   done          one-cycle pulse when the result is valid
//   x, err        result and framing error, held until the next start
//   count         words accepted in the current or last instance
//   sig           (SPLIT_STREAM_SIG_EN only) word signature
module split_stream #(
  parameter int unsigned NUM_VARS = 150,
  parameter int unsigned DATA_W = 16,
  parameter logic [DATA_W-1:0] LIMIT = {DATA_W{1'b1}},
  parameter int unsigned MODE = 0,
  localparam int unsigned IDX_W = $clog2(NUM_VARS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic              x,
  output logic              err,
`ifdef SPLIT_STREAM_SIG_EN
  output logic [DATA_W-1:0] sig,
`endif
  output logic [IDX_W-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   count_q, count_d;
  logic               x_q, x_d;
  logic               err_q, err_d;
  logic               xfer;
  logic               at_end;
  logic               terminal;

  assign in_ready = (state_q == COLLECT);
  assign busy     = (state_q == COLLECT);
  assign done     = (state_q == DONE);
  assign x        = x_q;
  assign err      = err_q;
  assign count    = count_q;

  assign xfer     = in_valid && (state_q == COLLECT);
  // Current word is the last position of the frame.
  assign at_end   = (count_q == IDX_W'(NUM_VARS - 1));
  assign terminal = xfer && (in_last || at_end);

  // Datapath next values for an accepted word.
  always_comb begin
    count_d = count_q + IDX_W'(1);
    x_d     = x_q;
    if (MODE == 1) begin
      x_d = x_q && (in_data <= LIMIT);
    end
    // Short frame or missing last marker.
    err_d   = err_q || (in_last != at_end);
  end

`ifdef SPLIT_STREAM_SIG_EN
  logic [DATA_W-1:0] sig_q, sig_d;
  assign sig   = sig_q;
  assign sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      sig_q <= '0;
    end else if (xfer) begin
      sig_q <= sig_d;
    end
  end
`endif

  // Control FSM and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      x_q     <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COLLECT;
            count_q <= '0;
            x_q     <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        COLLECT: begin
          if (xfer) begin
            count_q <= count_d;
            x_q     <= x_d;
            if (terminal) begin
              err_q   <= err_d;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_split_stream.sv
module tb_split_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;

  logic        rdy0, busy0, done0, x0, err0;
  logic [7:0]  cnt0;
  logic        rdy1, busy1, done1, x1, err1;
  logic [7:0]  cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef SPLIT_STREAM_SIG_EN
  logic [15:0] sig0, sig1;
`endif

  split_stream dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(rdy0), .in_data(in_data), .in_last(in_last),
    .busy(busy0), .done(done0), .x(x0), .err(err0),
`ifdef SPLIT_STREAM_SIG_EN
    .sig(sig0),
`endif
    .count(cnt0)
  );

  split_stream #(.MODE(1), .LIMIT(16'h00FF)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(rdy1), .in_data(in_data), .in_last(in_last),
    .busy(busy1), .done(done1), .x(x1), .err(err1),
`ifdef SPLIT_STREAM_SIG_EN
    .sig(sig1),
`endif
    .count(cnt1)
  );

`ifdef SPLIT_STREAM_SIG_EN
  logic       s_start, s_valid, s_last;
  logic [7:0] s_data;
  logic       s_ready, s_busy, s_done, s_x, s_err;
  logic [1:0] s_count;
  logic [7:0] s_sig;

  split_stream #(.NUM_VARS(2), .DATA_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid),
    .in_ready(s_ready), .in_data(s_data), .in_last(s_last),
    .busy(s_busy), .done(s_done), .x(s_x), .err(s_err),
    .sig(s_sig), .count(s_count)
  );
`endif

  typedef struct {
    string       name;
    int          n;        // words sent (terminal after word n)
    int          last_at;  // word carrying in_last, 0 = none
    int          bad_at;   // word replaced by bad_val, 0 = none
    logic [15:0] bad_val;
    bit          gaps;     // random in_valid and start held high
    bit          exp_err;
    bit          exp_x1;   // expected x of the MODE 1 instance
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input int k, input vec_t v);
    return (k == v.bad_at) ? v.bad_val : 16'(k);
  endfunction

  task automatic run_vec(input vec_t v);
    int  k;
    int  cyc;
    bit  vld;
    k   = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk({v.name, ":busy_on_start"}, 32'(busy0), 32'd1);
    chk({v.name, ":count_cleared"}, 32'(cnt1), 32'd0);
    chk({v.name, ":x1_cleared"}, 32'(x1), 32'd1);
    @(negedge clk);
    if (!v.gaps) start = 1'b0;
    while (k < v.n && cyc < 2000) begin
      vld      = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = vld;
      in_data  = word(k + 1, v);
      in_last  = ((k + 1) == v.last_at);
      @(posedge clk); #1;
      cyc++;
      if (vld) k++;
      if (k < v.n) begin
        chk({v.name, ":no_early_done"}, 32'(done0 | done1), 32'd0);
        @(negedge clk);
      end
    end
    if (k < v.n) chk({v.name, ":word_timeout"}, 32'(k), 32'(v.n));
    chk({v.name, ":done0"}, 32'(done0), 32'd1);
    chk({v.name, ":done1"}, 32'(done1), 32'd1);
    chk({v.name, ":ready_in_done"}, 32'(rdy0), 32'd0);
    chk({v.name, ":count0"}, 32'(cnt0), 32'(v.n));
    chk({v.name, ":count1"}, 32'(cnt1), 32'(v.n));
    chk({v.name, ":err0"}, 32'(err0), 32'(v.exp_err));
    chk({v.name, ":err1"}, 32'(err1), 32'(v.exp_err));
    chk({v.name, ":x0"}, 32'(x0), 32'd1);
    chk({v.name, ":x1"}, 32'(x1), 32'(v.exp_x1));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk); #1;
    chk({v.name, ":done_one_cycle"}, 32'(done0 | done1), 32'd0);
    chk({v.name, ":idle_not_busy"}, 32'(busy0 | busy1), 32'd0);
    chk({v.name, ":count_held"}, 32'(cnt1), 32'(v.n));
    chk({v.name, ":x1_held"}, 32'(x1), 32'(v.exp_x1));
    chk({v.name, ":err_held"}, 32'(err0), 32'(v.exp_err));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({v.name, ":no_restart"}, 32'(busy0 | busy1), 32'd0);
  endtask

  initial begin
    bit saw_done;
    vecs[0] = '{"full",       150, 150,   0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"bad37",      150, 150,  37, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"short10",     10,  10,   0, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{"nolast",     150,   0,   0, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"gaps",       150, 150,   0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"bad_last",   150, 150, 150, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"short149",   149, 149,   0, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{"at_limit",   150, 150,   5, 16'h00FF, 1'b0, 1'b0, 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
`ifdef SPLIT_STREAM_SIG_EN
    s_start = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset:in_ready", 32'(rdy0 | rdy1), 32'd0);
    chk("reset:busy", 32'(busy0 | busy1), 32'd0);
    chk("reset:done", 32'(done0 | done1), 32'd0);
    chk("reset:x", 32'({x0, x1}), 32'd3);
    chk("reset:err", 32'(err0 | err1), 32'd0);
    chk("reset:count", 32'(cnt0 | cnt1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abandon an instance with reset after word 60 (word 30 out of range).
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 30) ? 16'h0100 : 16'(k);
      in_last  = 1'b0;
      @(negedge clk);
    end
    chk("rst_mid:pre_x1_low", 32'(x1), 32'd0);
    chk("rst_mid:pre_count", 32'(cnt0), 32'd60);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid:busy", 32'(busy0 | busy1), 32'd0);
    chk("rst_mid:x", 32'({x0, x1}), 32'd3);
    chk("rst_mid:count", 32'(cnt0 | cnt1), 32'd0);
    chk("rst_mid:err", 32'(err0 | err1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy0) saw_done = 1'b1;
    end
    chk("rst_mid:no_done_no_resume", 32'(saw_done), 32'd0);
    run_vec(vecs[0]);

`ifdef SPLIT_STREAM_SIG_EN
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h81;
    @(negedge clk);
    s_data  = 8'h01;
    s_last  = 1'b1;
    @(posedge clk); #1;
    chk("sig:done", 32'(s_done), 32'd1);
    chk("sig:value", 32'(s_sig), 32'h02);
    chk("sig:count", 32'(s_count), 32'd2);
    chk("sig:err", 32'(s_err), 32'd0);
    chk("sig:x_ready", 32'({s_x, s_ready}), 32'd2);
    chk("sig:busy", 32'(s_busy), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk); #1;
    chk("sig:held", 32'(s_sig), 32'h02);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 5000000");
    $fatal(1);
  end

endmodule
